// File: rtl/tape_arbiter_pkg.sv
// Shared definitions for the tape arbiter: default tape geometry and the
// ownership state encoding used by the arbitration FSM.
package tape_arbiter_pkg;

    localparam int TAPE_ADDR_WIDTH = 8;
    localparam int TAPE_DATA_WIDTH = 8;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } own_state_e;

endpackage

// File: rtl/tape_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment and
// the count sticks at MAX instead of wrapping.
module tape_arb_sat_counter
    import tape_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up while inc is high, hold at MAX, drop to zero on clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != WIDTH'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tape_arbiter.sv
// Tape RAM arbiter between the brainhack core and the host debug/loader port.
// One owner per cycle drives the RAM; read data comes back registered.
// Optional fairness (wait/lock limits) is built when TAPE_ARB_FAIR_EN is defined.
module tape_arbiter
    import tape_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = TAPE_ADDR_WIDTH,
    parameter int DATA_WIDTH = TAPE_DATA_WIDTH,
    parameter int WAIT_MAX   = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_stall,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic                  host_lock,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    own_state_e state;
    own_state_e state_next;
    logic       core_gnt;
    logic       fair_override;
    logic       lock_expired;

`ifdef TAPE_ARB_FAIR_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    tape_arb_sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (WAIT_MAX)
    ) u_wait_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (host_gnt),
        .inc     (host_req && !host_gnt),
        .count   (wait_cnt)
    );

    // lock_cnt holds the locked host grants already made in this burst, the
    // entry grant included, so the grant seen at LOCK_MAX-1 is the last one.
    tape_arb_sat_counter #(
        .WIDTH (LOCK_W),
        .MAX   (LOCK_MAX)
    ) u_lock_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_next == OWN_CORE),
        .inc     (host_gnt && host_lock),
        .count   (lock_cnt)
    );

    assign fair_override = host_req && (wait_cnt == WAIT_W'(WAIT_MAX));
    assign lock_expired  = (state == OWN_HOST) && (lock_cnt == LOCK_W'(LOCK_MAX - 1));
`else
    // Strict core priority: the host is never forced in and a lock never expires.
    assign fair_override = 1'b0 && (WAIT_MAX > 0);
    assign lock_expired  = 1'b0 && (LOCK_MAX > 0);
`endif

    // Ownership register; reset hands the tape back to the core.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= OWN_CORE;
        end else begin
            state <= state_next;
        end
    end

    // Grant decision and next ownership; nothing is granted while in reset.
    always_comb begin
        state_next = state;
        core_gnt   = 1'b0;
        host_gnt   = 1'b0;
        if (reset_n) begin
            case (state)
                OWN_CORE: begin
                    if (core_req && !fair_override) begin
                        core_gnt = 1'b1;
                    end else if (host_req) begin
                        host_gnt = 1'b1;
                        if (host_lock && !lock_expired) begin
                            state_next = OWN_HOST;
                        end
                    end
                end
                OWN_HOST: begin
                    if (host_req) begin
                        host_gnt = 1'b1;
                    end
                    if (!host_req || !host_lock || lock_expired) begin
                        state_next = OWN_CORE;
                    end
                end
                default: state_next = OWN_CORE;
            endcase
        end
    end

    // RAM port follows the granted requester; idle cycles show the core address.
    always_comb begin
        core_stall = core_req && !core_gnt && reset_n;
        ram_we     = 1'b0;
        ram_addr   = core_addr;
        ram_wdata  = core_wdata;
        if (host_gnt) begin
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end else if (core_gnt) begin
            ram_we = core_we;
        end
    end

    // Capture the RAM read (pre-write value on writes) for whoever was granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_rdata  <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            if (core_gnt) begin
                core_rdata <= ram_rdata;
            end
            if (host_gnt) begin
                host_rdata <= ram_rdata;
            end
            host_rvalid <= host_gnt;
        end
    end

endmodule

// File: tb/tb_tape_arbiter.sv
// Self-checking bench for tape_arbiter with a behavioural tape RAM.
// Fairness checks are built when TAPE_ARB_FAIR_EN is defined.
module tb_tape_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    typedef struct {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          hreq;
        logic          hwe;
        logic          hlock;
        logic [AW-1:0] haddr;
        logic [DW-1:0] hwd;
        logic          stall;
        logic          hgnt;
        logic          rwe;
        logic [AW-1:0] raddr;
        logic [DW-1:0] rwd;
        logic [DW-1:0] crd;
        logic          hrv;
        logic [DW-1:0] hrd;
    } vec_t;

    logic          clock;
    logic          reset_n;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          host_req;
    logic          host_we;
    logic          host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int   total;
    int   bad;
    vec_t vecs [17];

    tape_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_MAX   (8),
        .LOCK_MAX   (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Tape RAM: synchronous write, combinational read.
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        core_req   = v.creq;
        core_we    = v.cwe;
        core_addr  = v.caddr;
        core_wdata = v.cwd;
        host_req   = v.hreq;
        host_we    = v.hwe;
        host_lock  = v.hlock;
        host_addr  = v.haddr;
        host_wdata = v.hwd;
    endtask

    task automatic clearInputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
    endtask

    // One table row per clock: combinational checks mid-cycle, registered after the edge.
    task automatic runRows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkOutput($sformatf("row%0d core_stall", i), 8'(core_stall), 8'(vecs[i].stall));
            checkOutput($sformatf("row%0d host_gnt", i), 8'(host_gnt), 8'(vecs[i].hgnt));
            checkOutput($sformatf("row%0d ram_we", i), 8'(ram_we), 8'(vecs[i].rwe));
            checkOutput($sformatf("row%0d ram_addr", i), ram_addr, vecs[i].raddr);
            if (vecs[i].rwe) checkOutput($sformatf("row%0d ram_wdata", i), ram_wdata, vecs[i].rwd);
            @(posedge clock); #1;
            checkOutput($sformatf("row%0d core_rdata", i), core_rdata, vecs[i].crd);
            checkOutput($sformatf("row%0d host_rvalid", i), 8'(host_rvalid), 8'(vecs[i].hrv));
            checkOutput($sformatf("row%0d host_rdata", i), host_rdata, vecs[i].hrd);
        end
    endtask

    initial begin
        int gnt_count;
        int first_gnt;
        int last_gnt;
        total = 0;
        bad   = 0;
        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;

        //            creq cwe caddr  cwd    hreq hwe hlk haddr  hwd    stall hgnt rwe raddr  rwd    crd    hrv hrd
        vecs[0]  = '{T, T, 8'h03, 8'h2A, F, F, F, 8'h00, 8'h00, F, F, T, 8'h03, 8'h2A, 8'h00, F, 8'h00};
        vecs[1]  = '{T, F, 8'h03, 8'h00, F, F, F, 8'h00, 8'h00, F, F, F, 8'h03, 8'h00, 8'h2A, F, 8'h00};
        vecs[2]  = '{F, F, 8'h09, 8'h00, F, F, F, 8'h00, 8'h00, F, F, F, 8'h09, 8'h00, 8'h2A, F, 8'h00};
        vecs[3]  = '{T, T, 8'h03, 8'h55, F, F, F, 8'h00, 8'h00, F, F, T, 8'h03, 8'h55, 8'h2A, F, 8'h00};
        vecs[4]  = '{T, F, 8'h03, 8'h00, F, F, F, 8'h00, 8'h00, F, F, F, 8'h03, 8'h00, 8'h55, F, 8'h00};
        vecs[5]  = '{F, F, 8'h07, 8'h00, T, F, F, 8'h03, 8'h00, F, T, F, 8'h03, 8'h00, 8'h55, T, 8'h55};
        vecs[6]  = '{T, F, 8'h03, 8'h00, T, T, F, 8'h08, 8'h99, F, F, F, 8'h03, 8'h00, 8'h55, F, 8'h55};
        vecs[7]  = '{F, F, 8'h01, 8'h00, T, T, F, 8'h08, 8'h99, F, T, T, 8'h08, 8'h99, 8'h55, T, 8'h00};
        vecs[8]  = '{T, T, 8'h0A, 8'h11, T, F, F, 8'h08, 8'h00, F, F, T, 8'h0A, 8'h11, 8'h00, F, 8'h00};
        vecs[9]  = '{F, F, 8'h01, 8'h00, T, F, F, 8'h08, 8'h00, F, T, F, 8'h08, 8'h00, 8'h00, T, 8'h99};
        vecs[10] = '{T, F, 8'h0A, 8'h00, F, F, F, 8'h00, 8'h00, F, F, F, 8'h0A, 8'h00, 8'h11, F, 8'h99};
        // Locked host burst to 0..3 while the core waits, host_req drops before the lock.
        vecs[11] = '{F, F, 8'h0A, 8'h00, T, T, T, 8'h00, 8'hA0, F, T, T, 8'h00, 8'hA0, 8'h11, T, 8'h00};
        vecs[12] = '{T, F, 8'h0A, 8'h00, T, T, T, 8'h01, 8'hA1, T, T, T, 8'h01, 8'hA1, 8'h11, T, 8'h00};
        vecs[13] = '{T, F, 8'h0A, 8'h00, T, T, T, 8'h02, 8'hA2, T, T, T, 8'h02, 8'hA2, 8'h11, T, 8'h00};
        vecs[14] = '{T, F, 8'h0A, 8'h00, T, T, T, 8'h03, 8'hA3, T, T, T, 8'h03, 8'hA3, 8'h11, T, 8'h55};
        vecs[15] = '{T, F, 8'h0A, 8'h00, F, F, T, 8'h00, 8'h00, T, F, F, 8'h0A, 8'h00, 8'h11, F, 8'h55};
        vecs[16] = '{T, F, 8'h00, 8'h00, F, F, F, 8'h00, 8'h00, F, F, F, 8'h00, 8'h00, 8'hA0, F, 8'h55};

        // Reset with both requesters active: nothing may be granted.
        clearInputs();
        reset_n = 1'b0;
        core_req = 1; host_req = 1; host_we = 1; host_addr = 8'h06; host_wdata = 8'h66;
        @(negedge clock);
        checkOutput("reset core_stall", 8'(core_stall), 8'h0);
        checkOutput("reset host_gnt", 8'(host_gnt), 8'h0);
        checkOutput("reset ram_we", 8'(ram_we), 8'h0);
        @(posedge clock); #1;
        checkOutput("reset mem6", mem[6], 8'h00);
        checkOutput("reset core_rdata", core_rdata, 8'h00);
        checkOutput("reset host_rvalid", 8'(host_rvalid), 8'h0);
        checkOutput("reset host_rdata", host_rdata, 8'h00);
        clearInputs();
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Core write to cell 5 cut short by reset before the edge.
        core_req = 1; core_we = 1; core_addr = 8'h05; core_wdata = 8'h07;
        @(negedge clock);
        checkOutput("pre-reset ram_we", 8'(ram_we), 8'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset ram_we", 8'(ram_we), 8'h0);
        checkOutput("midreset core_stall", 8'(core_stall), 8'h0);
        checkOutput("midreset host_gnt", 8'(host_gnt), 8'h0);
        @(posedge clock); #1;
        checkOutput("midreset mem5", mem[5], 8'h00);
        checkOutput("midreset core_rdata", core_rdata, 8'h00);
        checkOutput("midreset host_rvalid", 8'(host_rvalid), 8'h0);
        clearInputs();
        reset_n = 1'b1;
        @(posedge clock); #1;

        runRows(0, 10);

`ifndef TAPE_ARB_FAIR_EN
        // Strict priority: a busy core starves the host indefinitely.
        core_req = 1; core_we = 0; core_addr = 8'h0A;
        host_req = 1; host_we = 0; host_lock = 0; host_addr = 8'h08;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            checkOutput($sformatf("starve%0d host_gnt", c), 8'(host_gnt), 8'h0);
            checkOutput($sformatf("starve%0d core_stall", c), 8'(core_stall), 8'h0);
            @(posedge clock); #1;
        end
        checkOutput("starve host_rvalid", 8'(host_rvalid), 8'h0);
        checkOutput("starve core_rdata", core_rdata, 8'h11);
        clearInputs();
`endif

        runRows(11, 16);
        checkOutput("burst mem1", mem[1], 8'hA1);
        checkOutput("burst mem2", mem[2], 8'hA2);
        checkOutput("burst mem3", mem[3], 8'hA3);

`ifdef TAPE_ARB_FAIR_EN
        // Forced host grant after WAIT_MAX losing cycles.
        core_req = 1; core_we = 0; core_addr = 8'h0A;
        host_req = 1; host_we = 0; host_lock = 0; host_addr = 8'h08;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("wait%0d host_gnt", c), 8'(host_gnt), 8'(c == 9));
            checkOutput($sformatf("wait%0d core_stall", c), 8'(core_stall), 8'(c == 9));
            @(posedge clock); #1;
            checkOutput($sformatf("wait%0d host_rvalid", c), 8'(host_rvalid), 8'(c == 9));
        end
        checkOutput("wait host_rdata", host_rdata, 8'h99);

        // Locked host held for 30 cycles against a busy core: burst capped at LOCK_MAX.
        host_lock = 1;
        gnt_count = 0; first_gnt = -1; last_gnt = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (host_gnt) begin
                gnt_count++;
                if (first_gnt < 0) first_gnt = c;
                last_gnt = c;
            end
            @(posedge clock); #1;
        end
        checkOutput("lock grant count", 8'(gnt_count), 8'd16);
        checkOutput("lock grant run", 8'(last_gnt - first_gnt + 1), 8'd16);
        clearInputs();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
